// File: rtl/kws_mac_accum.sv
// Keyword-spotting MAC accumulator: bias-seeded int32 accumulation of
// 4-lane int8 dot products with an input zero-point offset, one result per run.
module kws_mac_accum #(
  parameter int INPUT_OFFSET = 128
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic [31:0] i_bias,
  input  logic [7:0]  i_num_beats,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_in_input,
  input  logic [31:0] i_in_filter,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_out_acc,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic signed [8:0] OFFSET9 = 9'(INPUT_OFFSET);

  state_t      r_state;
  logic [31:0] r_acc;
  logic [7:0]  r_remaining;

  logic signed [16:0] w_prod [4];
  logic signed [18:0] w_lane_sum;
  logic [31:0]        w_beat_ext;
  logic               w_beat_accept;

  // Per-lane: offset activation (9-bit signed) times weight -> 17-bit product.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic signed [8:0] w_act;
      logic signed [7:0] w_wt;
      assign w_act = $signed({i_in_input[8*gi+7], i_in_input[8*gi +: 8]}) + OFFSET9;
      assign w_wt  = $signed(i_in_filter[8*gi +: 8]);
      assign w_prod[gi] = 17'(w_act) * 17'(w_wt);
    end
  endgenerate

  assign w_lane_sum = 19'(w_prod[0]) + 19'(w_prod[1]) + 19'(w_prod[2]) + 19'(w_prod[3]);
  assign w_beat_ext = {{13{w_lane_sum[18]}}, w_lane_sum};

  assign o_in_ready    = (r_state == S_ACCUM);
  assign o_out_valid   = (r_state == S_DONE);
  assign o_busy        = (r_state != S_IDLE);
  assign o_out_acc     = (r_state == S_DONE) ? r_acc : 32'd0;
  assign w_beat_accept = i_in_valid && (r_state == S_ACCUM);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_acc       <= 32'd0;
      r_remaining <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_acc       <= i_bias;
            r_remaining <= i_num_beats;
            r_state     <= (i_num_beats != 8'd0) ? S_ACCUM : S_DONE;
          end
        end
        S_ACCUM: begin
          if (w_beat_accept) begin
            r_acc       <= r_acc + w_beat_ext;
            r_remaining <= r_remaining - 8'd1;
            if (r_remaining == 8'd1) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // A start arriving alongside the handshake is dropped, not queued.
          if (i_out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kws_mac_accum.sv
// Directed bench for kws_mac_accum: vector table of full runs plus hand-written
// sequences for zero-beat, back-pressure and mid-run reset.
module tb_kws_mac_accum;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] bias = '0;
  logic [7:0]  num_beats = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_input = '0;
  logic [31:0] in_filter = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_acc;
  logic        busy;

  int checks = 0;
  int errors = 0;

  kws_mac_accum #(.INPUT_OFFSET(128)) dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_start     (start),
    .i_bias      (bias),
    .i_num_beats (num_beats),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_input  (in_input),
    .i_in_filter (in_filter),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_acc   (out_acc),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] bias;
    logic [7:0]  nb;
    logic [31:0] act;
    logic [31:0] wt;
    int          gap;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_outv"}, {31'd0, out_valid}, 32'd0);
    check({name, "_inrdy"}, {31'd0, in_ready}, 32'd0);
    check({name, "_acc"}, out_acc, 32'd0);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    bias = v.bias;
    num_beats = v.nb;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("in_ready_after_start", {31'd0, in_ready}, 32'd1);
    check("acc_zero_in_accum", out_acc, 32'd0);
    for (int b = 0; b < v.nb; b++) begin
      if (b > 0 && v.gap > 0) begin
        // Idle gap with a competing start that must be ignored.
        start = 1'b1;
        bias = 32'hDEAD_BEEF;
        num_beats = 8'd7;
        for (int g = 0; g < v.gap; g++) tick();
        start = 1'b0;
        check("gap_in_ready", {31'd0, in_ready}, 32'd1);
        check("gap_out_valid", {31'd0, out_valid}, 32'd0);
      end
      in_input = v.act;
      in_filter = v.wt;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
    end
    check("out_valid_after_last", {31'd0, out_valid}, 32'd1);
    check("out_acc", out_acc, v.exp);
    $display("vec %0d: bias=0x%08h beats=%0d act=0x%08h wt=0x%08h acc=0x%08h exp=0x%08h",
             idx, v.bias, v.nb, v.act, v.wt, out_acc, v.exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_idle("after_handshake");
  endtask

  initial begin
    vecs[0] = '{32'h0000_0000, 8'd1, 32'h0000_0000, 32'h0101_0101, 0, 32'h0000_0200};
    vecs[1] = '{32'hFFFF_FF9C, 8'd2, 32'h7F7F_7F7F, 32'hFFFF_FFFF, 3, 32'hFFFF_F7A4};
    vecs[2] = '{32'h7FFF_FFFF, 8'd1, 32'h0000_0000, 32'h0101_0101, 0, 32'h8000_01FF};
    vecs[3] = '{32'h0000_0000, 8'd1, 32'h8080_8080, 32'h7F7F_7F7F, 0, 32'h0000_0000};
    vecs[4] = '{32'h0000_000A, 8'd1, 32'h7F00_0000, 32'h8001_0203, 0, 32'hFFFF_838A};
    vecs[5] = '{32'h0000_0000, 8'd3, 32'h7F7F_7F7F, 32'h8080_8080, 1, 32'hFFFA_0600};

    // Reset state
    #2;
    check_idle("reset");
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check_idle("post_reset");

    for (int i = 0; i < 6; i++) run_vec(i);

    // Zero-beat run: straight to DONE, in_ready never rises
    bias = 32'h1234_5678;
    num_beats = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("nb0_out_valid", {31'd0, out_valid}, 32'd1);
    check("nb0_in_ready", {31'd0, in_ready}, 32'd0);
    check("nb0_out_acc", out_acc, 32'h1234_5678);
    $display("nb0: acc=0x%08h exp=0x12345678", out_acc);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_idle("nb0_done");

    // Back-pressure: result held 5 cycles, start ignored, then handshake+start
    bias = 32'h0;
    num_beats = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_input = 32'h0;
    in_filter = 32'h0101_0101;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      bias = 32'h5555_5555;
      num_beats = 8'd0;
      tick();
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_out_acc", out_acc, 32'h0000_0200);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    check_idle("hold_release");
    tick();
    check_idle("hold_release_stays");
    $display("backpressure: acc held 0x00000200 for 5 cycles");

    // Mid-run reset after beat 1 of 3
    bias = 32'h0000_1000;
    num_beats = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_input = 32'h7F7F_7F7F;
    in_filter = 32'h0101_0101;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("midrun_busy", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_idle("async_reset");
    tick();
    reset_n = 1'b1;
    tick();
    check_idle("after_async_reset");
    run_vec(0);
    $display("midrun reset: recovered run checked");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
